// File: rtl/modn_counter_ctrl.sv
// Run controller for a programmable mod-N counter: accepts {modulus, periods}
// over valid/ready, counts the requested full periods, supports abort.
module modn_counter_ctrl #(
    parameter int MSB   = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [MSB-1:0]   cfg_mod,
    input  logic [WRAPW-1:0] cfg_wraps,
    input  logic             stop,
    output logic [MSB-1:0]   count,
    output logic             tc,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshake: a command transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high only in IDLE, so the master
    // may hold cfg_valid and the command is taken at the first IDLE edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MSB-1:0]   r_count;
    logic [MSB-1:0]   w_count_nxt;
    logic [WRAPW-1:0] r_wrap_cnt;
    logic [WRAPW-1:0] w_wrap_cnt_nxt;
    logic [MSB-1:0]   r_mod_q;
    logic [MSB-1:0]   w_mod_nxt;
    logic [WRAPW-1:0] r_wraps_q;
    logic [WRAPW-1:0] w_wraps_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_last;
    logic [WRAPW-1:0] w_wrap_inc;

    assign w_last     = (r_count == (r_mod_q - MSB'(1)));
    assign w_wrap_inc = r_wrap_cnt + WRAPW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_wrap_cnt <= '0;
            r_mod_q    <= '0;
            r_wraps_q  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
            r_mod_q    <= w_mod_nxt;
            r_wraps_q  <= w_wraps_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_mod_nxt      = r_mod_q;
        w_wraps_nxt    = r_wraps_q;
        w_err_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_mod >= MSB'(2)) begin
                        w_mod_nxt      = cfg_mod;
                        w_wraps_nxt    = cfg_wraps;
                        w_count_nxt    = '0;
                        w_wrap_cnt_nxt = '0;
                        w_state_nxt    = RUN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident final wrap and drops that wrap.
                if (stop) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_count_nxt    = '0;
                    w_wrap_cnt_nxt = w_wrap_inc;
                    if ((r_wraps_q != '0) && (w_wrap_inc == r_wraps_q)) begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_count_nxt = r_count + MSB'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign tc        = (r_state == RUN) && w_last;
    assign count     = r_count;
    assign wrap_cnt  = r_wrap_cnt;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_modn_counter_ctrl.sv
// Bench for modn_counter_ctrl: per-cycle expected output snapshots are queued
// when a command is issued and compared on each falling edge.
module tb_modn_counter_ctrl;

  localparam int MSB   = 4;
  localparam int WRAPW = 8;
  localparam int W     = MSB + WRAPW + 5;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [MSB-1:0]   cfg_mod;
  logic [WRAPW-1:0] cfg_wraps;
  logic             stop;
  logic [MSB-1:0]   count;
  logic             tc;
  logic [WRAPW-1:0] wrap_cnt;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] obs;

  modn_counter_ctrl #(.MSB(MSB), .WRAPW(WRAPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mod   (cfg_mod),
    .cfg_wraps (cfg_wraps),
    .stop      (stop),
    .count     (count),
    .tc        (tc),
    .wrap_cnt  (wrap_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  assign obs = {count, tc, wrap_cnt, busy, done, err, cfg_ready};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // snapshot order: count, tc, wrap_cnt, busy, done, err, cfg_ready
  function automatic logic [W-1:0] pk(input int c, input logic t, input int w,
                                      input logic b, input logic d,
                                      input logic e, input logic r);
    logic [MSB-1:0]   cc;
    logic [WRAPW-1:0] ww;
    cc = MSB'(c);
    ww = WRAPW'(w);
    return {cc, t, ww, b, d, e, r};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tc=%b wrap=%0d busy=%b done=%b err=%b ready=%b, expected count=%0d tc=%b wrap=%0d busy=%b done=%b err=%b ready=%b",
               tag, got[W-1 -: MSB], got[WRAPW+4], got[WRAPW+3:4], got[3], got[2], got[1], got[0],
               want[W-1 -: MSB], want[WRAPW+4], want[WRAPW+3:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // scoreboard: one expected snapshot per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  task automatic push(input string name, input int idx, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back($sformatf("%s[%0d]", name, idx));
  endtask

  // expected snapshots for one bounded run of n x w starting at index base
  task automatic push_run(input string name, input int base, input int n, input int w);
    for (int k = 0; k < n * w; k++)
      push(name, base + k, pk(k % n, (k % n) == n - 1, k / n, 1'b1, 1'b0, 1'b0, 1'b0));
    push(name, base + n * w, pk(0, 1'b0, w, 1'b0, 1'b1, 1'b0, 1'b0));
    push(name, base + n * w + 1, pk(0, 1'b0, w, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // present a command for one edge; returns in the cycle after that edge
  task automatic send(input int m, input int w);
    cfg_mod   = MSB'(m);
    cfg_wraps = WRAPW'(w);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, W'(exp_q.size()), W'(0));
      exp_q.delete();
      tag_q.delete();
    end
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mod   = '0;
    cfg_wraps = '0;
    stop      = 1'b0;
    #1;
    check("reset_state", obs, pk(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc();

    // reset in the middle of a 10 x 3 run, during the second period
    send(10, 3);
    for (int k = 0; k < 15; k++)
      push("pre_rst", k, pk(k % 10, (k % 10) == 9, k / 10, 1'b1, 1'b0, 1'b0, 1'b0));
    drain("pre_rst");
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", obs, pk(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // bounded run 10 x 2
    send(10, 2);
    push_run("bounded", 0, 10, 2);
    drain("bounded");

    // rejected moduli: err pulse, wrap_cnt holds 2
    for (int m = 0; m < 2; m++) begin
      send(m, 5);
      push($sformatf("reject%0d", m), 0, pk(0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1));
      push($sformatf("reject%0d", m), 1, pk(0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1));
      drain("reject");
    end

    // free-run mod 3, stop sampled while count = 1 in the third period
    send(3, 0);
    for (int k = 0; k < 8; k++)
      push("freerun", k, pk(k % 3, (k % 3) == 2, k / 3, 1'b1, 1'b0, 1'b0, 1'b0));
    push("freerun", 8, pk(0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1));
    push("freerun", 9, pk(0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (7) @(posedge clk);
    #1;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    drain("freerun");

    // stop coincident with the only wrap of a 4 x 1 run
    send(4, 1);
    for (int k = 0; k < 4; k++)
      push("stopfinal", k, pk(k, k == 3, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    push("stopfinal", 4, pk(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    push("stopfinal", 5, pk(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    drain("stopfinal");

    // cfg_valid held through two 15 x 1 runs; the second is taken at the
    // first edge that sees cfg_ready after the DONE cycle
    cfg_mod   = MSB'(15);
    cfg_wraps = WRAPW'(1);
    cfg_valid = 1'b1;
    cyc();
    push_run("b2b_a", 0, 15, 1);
    push_run("b2b_b", 17, 15, 1);
    repeat (17) @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    drain("b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
